// File: rtl/ps_pkg.sv
// Shared definitions for the program-sequencer fetch path.
//   PS_PMA_SIZE / PS_PMD_SIZE : default PM address / instruction widths
//   PS_RESET_VECTOR           : default first fetch address after reset
//   FQ_DEPTH                  : fetch queue depth
//   fq_entry_t                : one fetch-queue entry, {inst, pc}
package ps_pkg;

  localparam int PS_PMA_SIZE = 16;
  localparam int PS_PMD_SIZE = 32;
  localparam logic [PS_PMA_SIZE-1:0] PS_RESET_VECTOR = '0;
  localparam int FQ_DEPTH = 2;

  typedef struct packed {
    logic [PS_PMD_SIZE-1:0] inst;
    logic [PS_PMA_SIZE-1:0] pc;
  } fq_entry_t;

endpackage

// File: rtl/ps_fetch_queue.sv
// Two-entry synchronous FIFO holding fetched {inst, pc} words for decode.
//   clk, reset : clock, synchronous active-high reset (clears contents too)
//   push       : write wr_data at the tail
//   pop        : drop the head entry
//   flush      : empty the queue (wins over push/pop)
//   wr_data    : entry to write
//   head       : entry at the queue head (meaningful when count != 0)
//   count      : number of valid entries, 0..2
// The caller guarantees no push into a full queue without a pop.
module ps_fetch_queue
  import ps_pkg::*;
#(
  parameter int ENTRY_W = $bits(fq_entry_t)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic               pop,
  input  logic               flush,
  input  logic [ENTRY_W-1:0] wr_data,
  output logic [ENTRY_W-1:0] head,
  output logic [1:0]         count
);

  logic [ENTRY_W-1:0] mem [FQ_DEPTH];
  logic               rd_ptr;
  logic               wr_ptr;

  assign head = mem[rd_ptr];

  // When full, wr_ptr == rd_ptr: a simultaneous push+pop overwrites the
  // slot being read out this cycle, which then becomes the new tail.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
      for (int i = 0; i < FQ_DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/ps_fetch_unit.sv
// Program-sequencer instruction fetch stage in front of the PM read port.
// Issues sequential PM reads, captures the registered read data one cycle
// later into a 2-entry queue, and presents the queue head to decode.
//   clk, reset        : clock, synchronous active-high reset
//   ps_stall          : decode cannot take the head this cycle
//   ps_branch_en      : redirect fetch to ps_branch_addr, flushing the queue
//   ps_branch_addr    : redirect target
//   ps_pm_chipSelect  : PM read request this cycle
//   ps_pm_RbW         : PM read/write select, always read (0)
//   ps_pm_a           : PM read address
//   pmDataOut         : PM read data, valid the cycle after a request
//   ps_inst           : instruction at the queue head
//   ps_inst_pc        : address of ps_inst
//   ps_inst_valid     : ps_inst / ps_inst_pc are valid
module ps_fetch_unit
  import ps_pkg::*;
#(
  parameter int                  PMA_SIZE     = PS_PMA_SIZE,
  parameter int                  PMD_SIZE     = PS_PMD_SIZE,
  parameter logic [PMA_SIZE-1:0] RESET_VECTOR = PS_RESET_VECTOR
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ps_stall,
  input  logic                ps_branch_en,
  input  logic [PMA_SIZE-1:0] ps_branch_addr,
  output logic                ps_pm_chipSelect,
  output logic                ps_pm_RbW,
  output logic [PMA_SIZE-1:0] ps_pm_a,
  input  logic [PMD_SIZE-1:0] pmDataOut,
  output logic [PMD_SIZE-1:0] ps_inst,
  output logic [PMA_SIZE-1:0] ps_inst_pc,
  output logic                ps_inst_valid
);

  localparam int                  ENTRY_W = PMD_SIZE + PMA_SIZE;
  localparam logic [PMA_SIZE-1:0] PC_STEP = PMA_SIZE'(1);

  logic [PMA_SIZE-1:0] pc_p0;
  logic                vld_p1;
  logic [PMA_SIZE-1:0] pc_p1;
  logic                issue;
  logic                push;
  logic                pop;
  logic [2:0]          occ;
  logic [1:0]          fq_count;
  logic [ENTRY_W-1:0]  fq_head;

  // Stage p0: request. Occupancy counts queued words after this cycle's pop
  // plus the word already in flight; keeping it below the queue depth means
  // every returning word always has a slot.
  assign ps_inst_valid    = (fq_count != 2'd0) && !ps_branch_en && !reset;
  assign pop              = ps_inst_valid && !ps_stall;
  assign occ              = {1'b0, fq_count} - {2'b00, pop} + {2'b00, vld_p1};
  assign issue            = ps_branch_en || (occ < 3'(FQ_DEPTH));
  assign ps_pm_chipSelect = issue && !reset;
  assign ps_pm_a          = ps_branch_en ? ps_branch_addr : pc_p0;
  assign ps_pm_RbW        = 1'b0;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_p0  <= RESET_VECTOR;
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= issue;
      if (issue) pc_p0 <= ps_pm_a + PC_STEP;
    end
  end

  always_ff @(posedge clk) begin
    if (issue) pc_p1 <= ps_pm_a;
  end

  // Stage p1: PM data returns; a branch in this cycle makes it stale.
  assign push = vld_p1 && !ps_branch_en;

  ps_fetch_queue #(
    .ENTRY_W (ENTRY_W)
  ) u_fq (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .flush   (ps_branch_en),
    .wr_data ({pmDataOut, pc_p1}),
    .head    (fq_head),
    .count   (fq_count)
  );

  // Stage p2: queue head to decode.
  assign ps_inst    = reset ? '0 : fq_head[ENTRY_W-1:PMA_SIZE];
  assign ps_inst_pc = reset ? '0 : fq_head[PMA_SIZE-1:0];

endmodule

// File: tb/tb_ps_fetch_unit.sv
// Bench for ps_fetch_unit: cycle-exact vector table, directed corner-case
// sequences, then randomized stall/branch/reset traffic against a
// stream-level model of the delivered instruction sequence.
module tb_ps_fetch_unit;
  import ps_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        ps_stall;
  logic        ps_branch_en;
  logic [15:0] ps_branch_addr;
  logic        ps_pm_chipSelect;
  logic        ps_pm_RbW;
  logic [15:0] ps_pm_a;
  logic [31:0] pmDataOut;
  logic [31:0] ps_inst;
  logic [15:0] ps_inst_pc;
  logic        ps_inst_valid;

  int total = 0;
  int bad   = 0;

  ps_fetch_unit dut (
    .clk              (clk),
    .reset            (reset),
    .ps_stall         (ps_stall),
    .ps_branch_en     (ps_branch_en),
    .ps_branch_addr   (ps_branch_addr),
    .ps_pm_chipSelect (ps_pm_chipSelect),
    .ps_pm_RbW        (ps_pm_RbW),
    .ps_pm_a          (ps_pm_a),
    .pmDataOut        (pmDataOut),
    .ps_inst          (ps_inst),
    .ps_inst_pc       (ps_inst_pc),
    .ps_inst_valid    (ps_inst_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [15:0] a);
    return 32'h0000_0100 + {16'h0000, a};
  endfunction

  // Registered PM: data for a request appears the following cycle; idle
  // cycles return a poison pattern so unrequested captures are visible.
  always @(posedge clk) pmDataOut <= ps_pm_chipSelect ? word(ps_pm_a) : 32'hDEAD_BEEF;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rst, input logic st, input logic br, input logic [15:0] ba);
    reset          = rst;
    ps_stall       = st;
    ps_branch_en   = br;
    ps_branch_addr = ba;
    #2;
  endtask

  task automatic chk_head(input string tag, input logic [15:0] pc);
    check({tag, "_valid"}, ps_inst_valid, 1'b1);
    check({tag, "_pc"}, ps_inst_pc, pc);
    check({tag, "_inst"}, ps_inst, word(pc));
  endtask

  typedef struct {
    logic        stall;
    logic        br;
    logic [15:0] baddr;
    logic        cs;
    logic [15:0] a;
    logic        vld;
    logic [15:0] pc;
  } vec_t;

  vec_t tbl [16];

  initial begin
    logic [15:0] exp_pc;
    int          since;
    logic        rst_r, st_r, br_r;
    logic [15:0] ba_r;

    // Cycle 0 is the first cycle with reset low.
    tbl[0]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0, 16'h0000};
    tbl[1]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0001, 1'b0, 16'h0000};
    tbl[2]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0002, 1'b1, 16'h0000};
    tbl[3]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0003, 1'b1, 16'h0001};
    tbl[4]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0004, 1'b1, 16'h0002};
    tbl[5]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0004, 1'b1, 16'h0002};
    tbl[6]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0004, 1'b1, 16'h0002};
    tbl[7]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0004, 1'b1, 16'h0002};
    tbl[8]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0004, 1'b1, 16'h0002};
    tbl[9]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0005, 1'b1, 16'h0003};
    tbl[10] = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0006, 1'b1, 16'h0004};
    tbl[11] = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0006, 1'b1, 16'h0004};
    tbl[12] = '{1'b0, 1'b1, 16'h0040, 1'b1, 16'h0040, 1'b0, 16'h0000};
    tbl[13] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0041, 1'b0, 16'h0000};
    tbl[14] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0042, 1'b1, 16'h0040};
    tbl[15] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0043, 1'b1, 16'h0041};

    reset = 1'b1; ps_stall = 1'b0; ps_branch_en = 1'b0; ps_branch_addr = '0;
    cyc();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, 1'b0, 16'h0);
      check("rst_cs", ps_pm_chipSelect, 1'b0);
      check("rst_valid", ps_inst_valid, 1'b0);
      check("rst_inst", ps_inst, 32'h0);
      check("rst_pc", ps_inst_pc, 16'h0);
      check("rst_rbw", ps_pm_RbW, 1'b0);
      cyc();
    end

    // Startup, stall, branch with a full queue.
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, tbl[i].stall, tbl[i].br, tbl[i].baddr);
      check($sformatf("vec%0d_cs", i), ps_pm_chipSelect, tbl[i].cs);
      check($sformatf("vec%0d_a", i), ps_pm_a, tbl[i].a);
      check($sformatf("vec%0d_valid", i), ps_inst_valid, tbl[i].vld);
      if (tbl[i].vld) begin
        check($sformatf("vec%0d_pc", i), ps_inst_pc, tbl[i].pc);
        check($sformatf("vec%0d_inst", i), ps_inst, word(tbl[i].pc));
      end
      cyc();
    end

    // Branch near the top of the address space: PC wraps to zero.
    drive(1'b0, 1'b0, 1'b1, 16'hFFFE);
    check("wrap_br_valid", ps_inst_valid, 1'b0);
    check("wrap_br_a", ps_pm_a, 16'hFFFE);
    cyc();
    drive(1'b0, 1'b0, 1'b0, 16'h0);
    check("wrap_gap_valid", ps_inst_valid, 1'b0);
    cyc();
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 1'b0, 1'b0, 16'h0);
      chk_head($sformatf("wrap%0d", k), 16'hFFFE + 16'(k));
      cyc();
    end

    // Branch together with stall, then stall held: target held at head.
    drive(1'b0, 1'b1, 1'b1, 16'h1234);
    check("brst_valid", ps_inst_valid, 1'b0);
    check("brst_cs", ps_pm_chipSelect, 1'b1);
    check("brst_a", ps_pm_a, 16'h1234);
    cyc();
    drive(1'b0, 1'b1, 1'b0, 16'h0);
    check("brst1_valid", ps_inst_valid, 1'b0);
    cyc();
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b1, 1'b0, 16'h0);
      chk_head($sformatf("brst_hold%0d", k), 16'h1234);
      check($sformatf("brst_hold%0d_cs", k), ps_pm_chipSelect, 1'b0);
      cyc();
    end
    drive(1'b0, 1'b0, 1'b0, 16'h0);
    chk_head("brst_rel0", 16'h1234);
    cyc();
    drive(1'b0, 1'b0, 1'b0, 16'h0);
    chk_head("brst_rel1", 16'h1235);
    cyc();

    // Reset mid-stream with stall high and a read in flight.
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 1'b1, 1'b0, 16'h0);
      check($sformatf("mrst%0d_cs", k), ps_pm_chipSelect, 1'b0);
      check($sformatf("mrst%0d_valid", k), ps_inst_valid, 1'b0);
      check($sformatf("mrst%0d_inst", k), ps_inst, 32'h0);
      check($sformatf("mrst%0d_pc", k), ps_inst_pc, 16'h0);
      cyc();
    end
    drive(1'b0, 1'b0, 1'b0, 16'h0);
    check("mrst_c0_a", ps_pm_a, 16'h0000);
    check("mrst_c0_cs", ps_pm_chipSelect, 1'b1);
    check("mrst_c0_valid", ps_inst_valid, 1'b0);
    cyc();
    drive(1'b0, 1'b0, 1'b0, 16'h0);
    check("mrst_c1_valid", ps_inst_valid, 1'b0);
    cyc();
    drive(1'b0, 1'b0, 1'b0, 16'h0);
    chk_head("mrst_c2", 16'h0000);
    cyc();

    // Random traffic against the instruction-stream model.
    exp_pc = 16'h0;
    since  = 0;
    for (int i = 0; i < 3000; i++) begin
      rst_r = (i < 2) || ($urandom_range(0, 199) == 0);
      st_r  = ($urandom_range(0, 99) < 35);
      br_r  = ($urandom_range(0, 99) < 6);
      ba_r  = ($urandom_range(0, 3) == 0) ? (16'hFFFC + 16'($urandom_range(0, 3)))
                                          : 16'($urandom_range(0, 65535));
      drive(rst_r, st_r, br_r, ba_r);
      check("rnd_rbw", ps_pm_RbW, 1'b0);
      if (rst_r) begin
        check("rnd_rst_cs", ps_pm_chipSelect, 1'b0);
        check("rnd_rst_valid", ps_inst_valid, 1'b0);
        check("rnd_rst_inst", ps_inst, 32'h0);
        check("rnd_rst_pc", ps_inst_pc, 16'h0);
        exp_pc = 16'h0;
        since  = 0;
      end else begin
        check("rnd_fq_le_depth", (dut.fq_count <= 2'd2), 1'b1);
        check("rnd_no_overflow", dut.push && (dut.fq_count == 2'd2) && !dut.pop, 1'b0);
        if (br_r) begin
          check("rnd_br_valid", ps_inst_valid, 1'b0);
          check("rnd_br_cs", ps_pm_chipSelect, 1'b1);
          check("rnd_br_a", ps_pm_a, ba_r);
          exp_pc = ba_r;
          since  = 1;
        end else begin
          if (since >= 2) check("rnd_valid", ps_inst_valid, 1'b1);
          if (ps_inst_valid) begin
            check("rnd_pc", ps_inst_pc, exp_pc);
            check("rnd_inst", ps_inst, word(exp_pc));
            if (!st_r) exp_pc = exp_pc + 16'h1;
          end
          if (since < 2) since++;
        end
      end
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps_fetch_unit.md
Name: ps_fetch_unit

Overview:
- Program-sequencer instruction fetch stage, directly upstream of the memory block's PM read port.
- Drives the PM address, chip-select and RbW, captures the registered PM read data one cycle later, and holds it in a 2-entry instruction queue feeding decode.
- Supports a decode stall and a branch redirect that flushes the queue.
- Sustains one instruction per cycle when decode is not stalled.

Parameters:
PMA_SIZE, 16, program memory address width
PMD_SIZE, 32, program memory data (instruction) width
RESET_VECTOR, 0, first fetch address after reset (PMA_SIZE bits)

Ports:
clk  in  1  system clock; all state updates on posedge
reset  in  1  synchronous, active-high reset
ps_stall  in  1  decode cannot accept an instruction this cycle
ps_branch_en  in  1  redirect fetch this cycle
ps_branch_addr  in  PMA_SIZE  redirect target
ps_pm_chipSelect  out  PMA-port 1  PM read request this cycle
ps_pm_RbW  out  1  read/write select; constant 0 (read)
ps_pm_a  out  PMA_SIZE  PM read address
pmDataOut  in  PMD_SIZE  PM read data, valid the cycle after a request
ps_inst  out  PMD_SIZE  instruction at queue head
ps_inst_pc  out  PMA_SIZE  address of ps_inst
ps_inst_valid  out  1  ps_inst/ps_inst_pc valid

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high.
- State: pc (next sequential fetch address); inflight (1 bit) plus inflight_pc; 2-entry FIFO of {inst, pc}; count 0..2.
- Reset (sampled at posedge):
  - pc <= RESET_VECTOR; count <= 0; inflight <= 0; FIFO contents <= 0.
  - While reset is high: ps_pm_chipSelect=0, ps_inst_valid=0, ps_inst=0, ps_inst_pc=0.
  - Any in-flight read is discarded.
- Pop: ps_inst_valid && !ps_stall.
- ps_inst_valid = (count != 0) && !ps_branch_en.
- Issue (combinational):
  - Branch cycle: issue = 1.
  - Otherwise: issue = (count - pop + inflight) < 2.
  - ps_pm_chipSelect = issue && !reset.
  - ps_pm_a = ps_branch_en ? ps_branch_addr : pc.
  - ps_pm_RbW = 0 always.
- On issue:
  - inflight <= 1; inflight_pc <= ps_pm_a.
  - pc <= ps_pm_a + 1, modulo 2^PMA_SIZE (0xFFFF wraps to 0x0000).
- Without issue: inflight <= 0; pc holds.
- Push: when inflight && !ps_branch_en, {pmDataOut, inflight_pc} is written to the FIFO tail.
- Count update: count_next = count + push - pop.
- Simultaneous push and pop is allowed at count 1 or 2.
- The issue rule guarantees no overflow. The bench asserts count never exceeds 2 and that push never occurs with count=2 && !pop.
- Latency:
  - Request at cycle T; data sampled at T+1; ps_inst_valid at T+2 (no bypass).
  - Steady state with no stall: one valid instruction per cycle, consecutive PCs.
- Stall:
  - Head holds stable while ps_stall=1.
  - The queue absorbs the one in-flight word; chipSelect drops once count + inflight reaches 2.
  - No instruction is lost or duplicated.
- Branch (ps_branch_en=1):
  - Overrides stall.
  - Queue flushed (count <= 0, no pop counted), current pmDataOut dropped.
  - Target fetched in the same cycle.
  - First target instruction valid 2 cycles later.
  - Back-to-back branches: the last one wins.
- Reset has priority over branch and stall.

Decomposition:
- Shared package (ps_pkg) holds:
  - PMA_SIZE and PMD_SIZE defaults
  - RESET_VECTOR
  - fetch-queue depth constant FQ_DEPTH=2
  - packed type for the {inst, pc} queue entry
- One sub-module, ps_fetch_queue: 2-entry synchronous FIFO with push, pop, flush, count and head outputs.
- Address, issue and inflight logic stay in ps_fetch_unit.

Test Plan:
1. Release reset (RESET_VECTOR=0), ps_stall=0, PM word[n]=n+0x100 -> ps_pm_a 0,1,2,... on consecutive cycles; ps_inst_valid first high 2 cycles after the first request with ps_inst=0x100, ps_inst_pc=0; then one per cycle.
2. Hold ps_stall=1 for 4 cycles mid-stream -> ps_pm_chipSelect low once 2 entries are queued; ps_inst stable; after release the PCs continue contiguously with no gap or duplicate.
3. With the queue full, pulse ps_branch_en with addr 0x0040 -> ps_inst_valid=0 in the branch cycle; ps_pm_a=0x0040 that cycle; next valid ps_inst_pc=0x0040 two cycles later; stale words never appear.
4. Branch to 0xFFFE -> delivered PCs 0xFFFE, 0xFFFF, 0x0000, 0x0001.
5. Assert reset mid-stream with ps_stall=1 and a read in flight -> outputs 0 while reset is high; after release, the first fetch is RESET_VECTOR and the in-flight data is discarded.
6. ps_branch_en and ps_stall high together, then stall held -> branch taken (queue flushed, target fetched); target instruction held at head until stall drops.
